ex_mem_register: RTL

Pipeline register between the execute stage (ALU) and the memory stage of the processor. Each cycle it captures the ALU result, the Z/N flags, the store data, the destination register and the control bits of the instruction leaving execute. It supports stall and flush, and keeps the architectural Z/N status register. It also resolves conditional branches against that status register and counts valid instructions passed downstream.

---
 rtl/ex_mem_if.sv | 42 ++++
 rtl/ex_mem_register.sv | 84 ++++++++
 2 files changed

// File: rtl/ex_mem_if.sv
// Execute-to-memory stage bundle: ex_* fields driven by the execute side,
// mem_* fields driven by the EX/MEM pipeline register.
interface ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
);
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic              ex_flagZ;
  logic              ex_flagN;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;
  logic              ex_set_flags;
  logic              ex_branch;
  logic [2:0]        ex_cond;

  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_store_data;
  logic [REG_W-1:0]  mem_rd;
  logic              mem_reg_write;
  logic              mem_mem_write;
  logic              mem_mem_to_reg;
  logic              mem_branch_taken;

  modport master (
    output ex_valid, ex_alu_result, ex_flagZ, ex_flagN, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_set_flags, ex_branch, ex_cond,
    input  mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_write, mem_mem_to_reg, mem_branch_taken
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_flagZ, ex_flagN, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_set_flags, ex_branch, ex_cond,
    output mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_write, mem_mem_to_reg, mem_branch_taken
  );
endinterface

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with stall/flush, architectural Z/N status flags,
// branch resolution against those flags, and a retired-instruction counter.
module ex_mem_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  ex_mem_if.slave     bus,
  input  logic        stall,
  input  logic        flush,
  output logic        flagZ_q,
  output logic        flagN_q,
  output logic [31:0] retired_count
);

  // Branch conditions evaluate against the flags held before this edge.
  function automatic logic cond_true(input logic [2:0] cond, input logic z, input logic n);
    logic res;
    case (cond)
      3'b000:  res = 1'b0;
      3'b001:  res = 1'b1;
      3'b010:  res = z;
      3'b011:  res = ~z;
      3'b100:  res = n;
      3'b101:  res = ~n;
      3'b110:  res = z | n;
      3'b111:  res = ~z & ~n;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic cond_true_s;

  // Condition decode from the current status register.
  always_comb begin
    cond_true_s = cond_true(bus.ex_cond, flagZ_q, flagN_q);
  end

  // Pipeline fields, status flags and counter; priority rst > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_valid        <= 1'b0;
      bus.mem_alu_result   <= {DATA_W{1'b0}};
      bus.mem_store_data   <= {DATA_W{1'b0}};
      bus.mem_rd           <= {REG_W{1'b0}};
      bus.mem_reg_write    <= 1'b0;
      bus.mem_mem_write    <= 1'b0;
      bus.mem_mem_to_reg   <= 1'b0;
      bus.mem_branch_taken <= 1'b0;
      flagZ_q              <= 1'b0;
      flagN_q              <= 1'b0;
      retired_count        <= 32'd0;
    end else if (flush) begin
      // Bubble: flags and counter deliberately keep their values.
      bus.mem_valid        <= 1'b0;
      bus.mem_alu_result   <= {DATA_W{1'b0}};
      bus.mem_store_data   <= {DATA_W{1'b0}};
      bus.mem_rd           <= {REG_W{1'b0}};
      bus.mem_reg_write    <= 1'b0;
      bus.mem_mem_write    <= 1'b0;
      bus.mem_mem_to_reg   <= 1'b0;
      bus.mem_branch_taken <= 1'b0;
    end else if (!stall) begin
      bus.mem_valid        <= bus.ex_valid;
      bus.mem_alu_result   <= bus.ex_alu_result;
      bus.mem_store_data   <= bus.ex_store_data;
      bus.mem_rd           <= bus.ex_rd;
      bus.mem_reg_write    <= bus.ex_valid & bus.ex_reg_write;
      bus.mem_mem_write    <= bus.ex_valid & bus.ex_mem_write;
      bus.mem_mem_to_reg   <= bus.ex_valid & bus.ex_mem_to_reg;
      bus.mem_branch_taken <= bus.ex_valid & bus.ex_branch & cond_true_s;
      if (bus.ex_valid && bus.ex_set_flags) begin
        flagZ_q <= bus.ex_flagZ;
        flagN_q <= bus.ex_flagN;
      end
      if (bus.ex_valid) begin
        retired_count <= retired_count + 32'd1;
      end
    end
  end

endmodule
